// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, prefix codes, parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Decoded-key bundle of the PS/2 receiver. key_en and frame_err are valid-only strobes with no
// ready: the consumer must capture key_in/key_break/key_ext on the single cycle key_en is high.
interface ps2_key_receiver_if;

    logic [7:0] key_in;
    logic       key_en;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;

    modport master (output key_in, key_en, key_break, key_ext, frame_err);
    modport slave  (input  key_in, key_en, key_break, key_ext, frame_err);

endinterface

// File: rtl/ps2_input_filter.sv
// 2-flop synchronizer plus a FILTER_LEN-sample glitch filter; FILTER_LEN<=1 gives the bare synchronizer.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], raw_i};
    end

    generate
        if (FILTER_LEN <= 1) begin : g_bypass
            assign filt_o = sync_q[1];
        end else begin : g_filter
            localparam int CW = $clog2(FILTER_LEN);
            logic [CW-1:0] cnt_q, cnt_d;
            logic          filt_q, filt_d;

            // The output flips on the FILTER_LEN-th consecutive differing sample.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync_q[1] != filt_q) begin
                    if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
                    else                               cnt_d  = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding and mid-frame timeout.
// Define PS2_PARITY_CHECK_EN to flag parity errors; otherwise the parity bit is ignored.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output ps2_state_e dbg_state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f, data_s, clk_f_prev_q, bit_ev, timeout;
    ps2_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d, key_in_q, key_in_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          par_err_q, par_err_d, ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic          key_en_q, key_en_d, key_brk_q, key_brk_d, key_ext_q, key_ext_d;
    logic          frame_err_q, frame_err_d;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i(clock), .rst_i(reset), .raw_i(ps2_clk), .filt_o(clk_f)
    );
    ps2_input_filter #(.FILTER_LEN(1)) u_data_sync (
        .clk_i(clock), .rst_i(reset), .raw_i(ps2_data), .filt_o(data_s)
    );

    assign bit_ev   = clk_f_prev_q & ~clk_f;
    assign timeout  = (state_q != PS2_IDLE) && !bit_ev && (to_cnt_q == TW'(TIMEOUT_CYCLES));
    assign to_cnt_d = bit_ev ? '0 :
                      (to_cnt_q == TW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + TW'(1);

    always_ff @(posedge clock) begin
        if (reset) state_q <= PS2_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = PS2_IDLE;
        end else if (bit_ev) begin
            case (state_q)
                PS2_IDLE:   if (!data_s) state_d = PS2_DATA;
                PS2_DATA:   if (bit_cnt_q == 3'd7) state_d = PS2_PARITY;
                PS2_PARITY: state_d = PS2_STOP;
                PS2_STOP:   state_d = PS2_IDLE;
                default:    state_d = PS2_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_err_d   = par_err_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_in_d    = key_in_q;
        key_brk_d   = key_brk_q;
        key_ext_d   = key_ext_q;
        key_en_d    = 1'b0;
        frame_err_d = 1'b0;
        if (timeout) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
        end else if (bit_ev) begin
            case (state_q)
                PS2_IDLE: bit_cnt_d = 3'd0;
                PS2_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PS2_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_err_d = !ps2_odd_parity_ok(shift_q, data_s);
`else
                    par_err_d = 1'b0;
`endif
                end
                PS2_STOP: begin
                    // A prefix byte only arms its flag; any other byte consumes both flags.
                    if (!data_s || par_err_q) begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end else if (shift_q == PS2_EXT_PREFIX) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == PS2_BRK_PREFIX) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        key_in_d   = shift_q;
                        key_ext_d  = ext_pend_q;
                        key_brk_d  = brk_pend_q;
                        key_en_d   = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_f_prev_q <= 1'b1;
            to_cnt_q     <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_err_q    <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            key_in_q     <= 8'h00;
            key_brk_q    <= 1'b0;
            key_ext_q    <= 1'b0;
            key_en_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_f_prev_q <= clk_f;
            to_cnt_q     <= to_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_err_q    <= par_err_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            key_in_q     <= key_in_d;
            key_brk_q    <= key_brk_d;
            key_ext_q    <= key_ext_d;
            key_en_q     <= key_en_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign key_in      = key_in_q;
    assign key_en      = key_en_q;
    assign key_break   = key_brk_q;
    assign key_ext     = key_ext_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Randomized and directed bench for ps2_key_receiver against a frame-level reference model.
module tb_ps2_key_receiver;
    import ps2_pkg::*;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    ps2_state_e dbg_state;

    ps2_key_receiver_if kif ();

    ps2_key_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_in     (kif.key_in),
        .key_en     (kif.key_en),
        .key_break  (kif.key_break),
        .key_ext    (kif.key_ext),
        .frame_err  (kif.frame_err),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    int         checks   = 0;
    int         failures = 0;
    int         err_seen = 0;
    int         exp_err  = 0;
    logic [9:0] exp_q[$];
    logic       model_ext = 1'b0, model_brk = 1'b0;
    logic [7:0] last_key  = 8'h00;
    logic       last_brk  = 1'b0, last_ext = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
    endtask

    // Frame-level model: prefixes arm flags, a good non-prefix byte emits one key, a bad frame clears flags.
    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_err++;
            model_ext = 1'b0;
            model_brk = 1'b0;
        end else if (b == 8'hE0) begin
            model_ext = 1'b1;
        end else if (b == 8'hF0) begin
            model_brk = 1'b1;
        end else begin
            exp_q.push_back({b, model_brk, model_ext});
            last_key  = b;
            last_brk  = model_brk;
            last_ext  = model_ext;
            model_ext = 1'b0;
            model_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        wait_cyc(10);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
        end else begin
            wait_cyc(3);
        end
        wait_cyc(7);
        ps2_clk = 1'b0;
        wait_cyc(40);
        ps2_clk = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int glitch_bit);
        logic [10:0] bits;
        model_frame(b, stop && (!PAR_CHK || (^{b, par})));
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clock);
        check({tag, "_missing_key"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_err_cnt"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_key_in"}, 32'(kif.key_in), 32'(last_key));
        check({tag, "_key_break"}, 32'(kif.key_break), 32'(last_brk));
        check({tag, "_key_ext"}, 32'(kif.key_ext), 32'(last_ext));
        check({tag, "_state_idle"}, 32'(dbg_state), 32'(PS2_IDLE));
    endtask

    // Scoreboard: every key_en strobe must match the oldest predicted key.
    always @(negedge clock) begin
        logic [9:0] e;
        if (!reset) begin
            if (kif.key_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_key_en", 32'(kif.key_in), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("key_strobe", 32'({kif.key_in, kif.key_break, kif.key_ext}), 32'(e));
                end
            end
            if (kif.frame_err) err_seen++;
            if (kif.key_en && kif.frame_err) check("en_err_overlap", 32'd1, 32'd0);
        end
    end

    initial begin
        #5ms;
        check("watchdog", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] b;
        logic       par, stop;
        int         r;

        reset = 1'b1;
        wait_cyc(5);
        @(negedge clock);
        check("rst_key_in", 32'(kif.key_in), 32'h00);
        check("rst_key_en", 32'(kif.key_en), 32'd0);
        check("rst_key_break", 32'(kif.key_break), 32'd0);
        check("rst_key_ext", 32'(kif.key_ext), 32'd0);
        check("rst_frame_err", 32'(kif.frame_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(PS2_IDLE));
        @(posedge clock);
        reset = 1'b0;
        wait_cyc(20);

        send_frame(8'h75, 1'b0, 1'b1, -1);
        checkpoint("plain_75");

        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h74, 1'b1, 1'b1, -1);
        checkpoint("ext_brk_74");
        send_frame(8'h6B, 1'b0, 1'b1, -1);
        checkpoint("after_prefix_6b");

        send_frame(8'h72, 1'b0, 1'b1, -1);
        checkpoint("bad_parity_72");

        send_frame(8'h74, 1'b1, 1'b0, -1);
        checkpoint("bad_stop");

        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        send_frame(8'h75, 1'b0, 1'b1, 4);
        checkpoint("glitch_75");

        // Pending E0 must be dropped by the timeout abort.
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        model_frame(8'h00, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i[0]), 1'b0);
        wait_cyc(TIMEOUT + 10);
        checkpoint("timeout");
        send_frame(8'h6B, 1'b0, 1'b1, -1);
        checkpoint("after_timeout_6b");

        // Reset mid-frame must drop the partial F0 and the pending E0, with no strobe.
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        reset = 1'b1;
        wait_cyc(3);
        reset     = 1'b0;
        model_ext = 1'b0;
        model_brk = 1'b0;
        last_key  = 8'h00;
        last_brk  = 1'b0;
        last_ext  = 1'b0;
        ps2_data  = 1'b1;
        wait_cyc(20);
        checkpoint("post_reset");
        send_frame(8'h72, 1'b1, 1'b1, -1);
        checkpoint("reset_then_72");

        for (int n = 0; n < 12; n++) begin
            r = int'($urandom_range(0, 7));
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            par = ~^b;
            if ($urandom_range(0, 7) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, par, stop, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
            checkpoint("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered ps2_clk changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clock cycles mid-frame before the frame is aborted.
REQ-003 SHALL have port clock, input, 1, the single system clock. All logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw asynchronous PS/2 device clock.
REQ-006 SHALL have port ps2_data, input, 1, raw asynchronous PS/2 device data.
REQ-007 SHALL have port key_in, output, 8, last decoded non-prefix scan code.
REQ-008 SHALL have port key_en, output, 1, one-cycle strobe marking key_in/key_break/key_ext valid.
REQ-009 SHALL have port key_break, output, 1, set when the code was preceded by 8'hF0 (release).
REQ-010 SHALL have port key_ext, output, 1, set when the code was preceded by 8'hE0 (extended key).
REQ-011 SHALL have port frame_err, output, 1, one-cycle strobe on a parity, start, stop or timeout error.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; ps2_clk is then filtered per FILTER_LEN.
REQ-013 SHALL treat a filtered ps2_clk 1->0 transition as a bit event and sample synchronized ps2_data on that cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY and STOP; IDLE->DATA only on a bit event with data=0 (start bit). A bit event with data=1 in IDLE SHALL be ignored with no error.
REQ-015 SHALL shift 8 data bits LSB-first in DATA, using a 3-bit counter; after bit 7 the state SHALL go to PARITY.
REQ-016 SHALL require odd parity over the 8 data bits plus the parity bit; the state SHALL go to STOP.
REQ-017 SHALL require stop bit = 1; on any error it SHALL pulse frame_err, clear both pending prefix flags, discard the byte and return to IDLE.
REQ-018 On a valid byte of 8'hE0, it SHALL set ext_pending and produce no key_en. On a valid 8'hF0, it SHALL set brk_pending and produce no key_en.
REQ-019 On any other valid byte, it SHALL load key_in, copy key_ext/key_break from the pending flags, pulse key_en, then clear the flags, all exactly 1 cycle after the stop-bit event.
REQ-020 key_in/key_break/key_ext SHALL hold between strobes. key_en and frame_err SHALL never assert together.
REQ-021 A timeout counter SHALL reset on every bit event. In a state other than IDLE, reaching TIMEOUT_CYCLES SHALL pulse frame_err and force IDLE. The counter SHALL saturate and never wrap.

Reset
REQ-022 Reset SHALL set the following: state IDLE; key_in 8'h00; key_en, key_break, key_ext and frame_err 0; pending flags, counters and shift register cleared; synchronizers and filter set to 1 (bus idle).
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no strobe; decoding SHALL restart at the next start bit.

Configuration
REQ-024 With macro PS2_PARITY_CHECK_EN defined, REQ-016 parity errors SHALL be flagged. Without it, the parity bit SHALL be sampled and ignored, and start, stop and timeout checks SHALL remain active.

Structure
REQ-025 Package ps2_pkg SHALL hold the state encoding and the constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0.
REQ-026 The synchronizer and filter SHALL be sub-module ps2_input_filter, instantiated for ps2_clk. ps2_data SHALL use its synchronizer only (filter bypassed by FILTER_LEN=1 instance).

Verification
REQ-027 Frame 0x75 with parity 0 and stop 1 -> one key_en, key_in=8'h75, key_break=0, key_ext=0, no frame_err.
REQ-028 Frames E0, F0, 74 -> exactly one key_en, with key_in=8'h74, key_ext=1, key_break=1. The next frame 6B -> key_ext=0, key_break=0.
REQ-029 Frame 0x72 with parity bit 0 -> frame_err pulse, no key_en when PS2_PARITY_CHECK_EN is defined; key_en with key_in=8'h72 when it is not.
REQ-030 Start bit plus 4 data bits, then silence for TIMEOUT_CYCLES+10 -> one frame_err, state IDLE. A following 0x6B frame -> key_in=8'h6B.
REQ-031 A 3-cycle low glitch on ps2_clk in IDLE and mid-frame -> no bit consumed, and 0x75 is still decoded correctly.
REQ-032 Reset pulsed after the 5th bit of a 0xF0 frame, followed by a 0x72 frame -> key_in=8'h72, key_break=0, no frame_err.
